// File: rtl/vga_pkg.sv
// Shared geometry defaults for the VGA timing generator: 640x480@60 with a
// 25 MHz pixel rate derived from the 50 MHz board clock.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_CLK_DIV  = 2;
  localparam int VGA_DIV_W    = 4;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus the active/sync decode of
// its current value. Used once for pixels within a line, once for lines.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int TOT = axis_total(ACTIVE, FP, SYNC, BP);

  // One extra bit so a boundary equal to 2^CW still compares correctly.
  localparam logic [CW:0] LAST     = (CW+1)'(TOT - 1);
  localparam logic [CW:0] ACT_END  = (CW+1)'(ACTIVE);
  localparam logic [CW:0] SYNC_BEG = (CW+1)'(ACTIVE + FP);
  localparam logic [CW:0] SYNC_END = (CW+1)'(ACTIVE + FP + SYNC);

  logic [CW:0] cnt_x;

  assign cnt_x  = {1'b0, count};
  assign wrap   = i_step && (cnt_x == LAST);
  assign active = cnt_x < ACT_END;
  assign sync   = (cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      count <= '0;
    end else if (i_step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v axis counters and a
// registered output stage that presents one pixel's decode per strobe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int CW       = 12,
  parameter int FCW      = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_run,
  output logic           o_pix_ce,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_de,
  output logic [CW-1:0]  o_x,
  output logic [CW-1:0]  o_y,
  output logic           o_line_start,
  output logic           o_frame_start,
  output logic [FCW-1:0] o_frame_cnt
);

  localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOT > 2**CW || V_TOT > 2**CW) begin : g_bad_cw
    $error("vga_timing_gen: H_TOT/V_TOT does not fit in CW bits");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be within 1..16");
  end

  localparam logic [VGA_DIV_W-1:0] DIV_LAST = VGA_DIV_W'(CLK_DIV - 1);
  localparam logic                 HP       = 1'(H_POL);
  localparam logic                 VP       = 1'(V_POL);

  logic [VGA_DIV_W-1:0] div_cnt;
  logic                 strobe;
  logic [CW-1:0]        h_count, v_count;
  logic                 h_wrap, h_active, h_sync;
  logic                 v_wrap_unused, v_active, v_sync;
  logic                 at_line_start, at_frame_start;

  assign strobe         = i_run && (div_cnt == DIV_LAST);
  assign at_line_start  = (h_count == '0);
  assign at_frame_start = at_line_start && (v_count == '0);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (!i_run),
    .i_step (strobe),
    .count  (h_count),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  // Lines advance only on the strobe where the pixel counter wraps.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (!i_run),
    .i_step (h_wrap),
    .count  (v_count),
    .wrap   (v_wrap_unused),
    .active (v_active),
    .sync   (v_sync)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      div_cnt       <= '0;
      o_pix_ce      <= 1'b0;
      o_hsync       <= ~HP;
      o_vsync       <= ~VP;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      // Stopping the raster keeps the frame count; only reset clears it.
      if (i_rst) begin
        o_frame_cnt <= '0;
      end
    end else begin
      div_cnt  <= strobe ? '0 : div_cnt + 1'b1;
      o_pix_ce <= strobe;
      if (strobe) begin
        o_hsync       <= h_sync ? HP : ~HP;
        o_vsync       <= v_sync ? VP : ~VP;
        o_de          <= h_active && v_active;
        o_x           <= h_count;
        o_y           <= v_count;
        o_line_start  <= at_line_start;
        o_frame_start <= at_frame_start;
        if (at_frame_start) begin
          o_frame_cnt <= o_frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (divide-by-1 / 2-bit frame count,
// divide-by-3 / inverted syncs) checked every cycle against a pixel-index model.
module tb_vga_timing_gen;

  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b1;

  always #5 clk = ~clk;

  logic        a_ce, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [11:0] a_x, a_y;
  logic [1:0]  a_fc;
  logic        b_ce, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [11:0] b_x, b_y;
  logic [7:0]  b_fc;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(1), .CW(12), .FCW(2)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_run(run),
    .o_pix_ce(a_ce), .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
    .o_x(a_x), .o_y(a_y), .o_line_start(a_ls), .o_frame_start(a_fs),
    .o_frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .CLK_DIV(3), .CW(12), .FCW(8)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_run(run),
    .o_pix_ce(b_ce), .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
    .o_x(b_x), .o_y(b_y), .o_line_start(b_ls), .o_frame_start(b_fs),
    .o_frame_cnt(b_fc)
  );

  typedef struct packed {
    logic ce, hs, vs, de, ls, fs;
    logic [11:0] x, y;
    logic [7:0]  fc;
  } exp_t;

  int errors = 0;
  int checks = 0;
  int ta = 0, ba = 0, tbb = 0, bb = 0;
  int cyc = 0;
  bit win = 0;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, ce_cnt_b = 0;
  int fs_first = -1, fs_second = -1;

  // Frame starts seen after n pixel strobes since the raster left idle.
  function automatic int frames(input int n);
    return (n == 0) ? 0 : (n - 1) / FR + 1;
  endfunction

  // t = edges with run=1 since the last reset/idle edge; base = held frame count.
  function automatic exp_t model(input int d, input int hpol, input int vpol,
                                 input int fcw, input int t, input int base);
    exp_t e;
    int n, p, x, y;
    n = t / d;
    e.ce = (t > 0) && (t % d == 0);
    if (n == 0) begin
      e.hs = (hpol == 0); e.vs = (vpol == 0);
      e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
      e.x = '0; e.y = '0;
    end else begin
      p = (n - 1) % FR;
      x = p % HT;
      y = p / HT;
      e.de = (x < 4) && (y < 3);
      e.hs = ((x >= 5) && (x < 7)) == (hpol != 0);
      e.vs = (y == 4) == (vpol != 0);
      e.ls = (x == 0);
      e.fs = (p == 0);
      e.x = 12'(x);
      e.y = 12'(y);
    end
    e.fc = 8'((base + frames(n)) % (1 << fcw));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic rn);
    exp_t ea, eb;
    @(negedge clk);
    rst = r;
    run = rn;
    @(posedge clk);
    cyc++;
    if (r) begin
      ta = 0; ba = 0; tbb = 0; bb = 0;
    end else if (!rn) begin
      ba = ba + frames(ta);      ta = 0;
      bb = bb + frames(tbb / 3); tbb = 0;
    end else begin
      ta++; tbb++;
    end
    #1;
    ea = model(1, 0, 0, 2, ta, ba);
    eb = model(3, 1, 1, 8, tbb, bb);
    chk("a_ce", 32'(a_ce), 32'(ea.ce));
    chk("a_hsync", 32'(a_hs), 32'(ea.hs));
    chk("a_vsync", 32'(a_vs), 32'(ea.vs));
    chk("a_de", 32'(a_de), 32'(ea.de));
    chk("a_x", 32'(a_x), 32'(ea.x));
    chk("a_y", 32'(a_y), 32'(ea.y));
    chk("a_line_start", 32'(a_ls), 32'(ea.ls));
    chk("a_frame_start", 32'(a_fs), 32'(ea.fs));
    chk("a_frame_cnt", 32'(a_fc), 32'(ea.fc));
    chk("b_ce", 32'(b_ce), 32'(eb.ce));
    chk("b_hsync", 32'(b_hs), 32'(eb.hs));
    chk("b_vsync", 32'(b_vs), 32'(eb.vs));
    chk("b_de", 32'(b_de), 32'(eb.de));
    chk("b_x", 32'(b_x), 32'(eb.x));
    chk("b_y", 32'(b_y), 32'(eb.y));
    chk("b_line_start", 32'(b_ls), 32'(eb.ls));
    chk("b_frame_start", 32'(b_fs), 32'(eb.fs));
    chk("b_frame_cnt", 32'(b_fc), 32'(eb.fc));
    if (win) begin
      de_cnt += int'(a_de);
      hs_cnt += int'(!a_hs);
      vs_cnt += int'(!a_vs);
      ce_cnt_b += int'(b_ce);
      if (a_fs) begin
        if (fs_first < 0) fs_first = cyc;
        else if (fs_second < 0) fs_second = cyc;
      end
    end
  endtask

  initial begin
    logic [1:0] fc_held;

    // Reset held: both instances at reset values (B idles syncs at 0).
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("rst_b_hsync_idle0", 32'(b_hs), 32'd0);
    chk("rst_b_vsync_idle0", 32'(b_vs), 32'd0);

    // Release: one exact frame of A inside the window.
    win = 1;
    for (int i = 0; i < FR; i++) step(1'b0, 1'b1);
    chk("a_frame_de_pixels", 32'(de_cnt), 32'd12);
    chk("a_frame_hsync_pixels", 32'(hs_cnt), 32'd12);
    chk("a_frame_vsync_pixels", 32'(vs_cnt), 32'd8);
    for (int i = FR; i < 3 * FR; i++) step(1'b0, 1'b1);
    chk("b_ce_per_frame", 32'(ce_cnt_b), 32'd48);
    chk("a_frame_start_period", 32'(fs_second - fs_first), 32'(FR));
    win = 0;

    // Run past four frames of A so the 2-bit count wraps.
    for (int i = 0; i < FR + 8; i++) step(1'b0, 1'b1);

    // Drop run at A pixel (2,1) and restart.
    for (int i = 0; i < FR && (ta % FR) != 11; i++) step(1'b0, 1'b1);
    chk("a_drop_x", 32'(a_x), 32'd2);
    chk("a_drop_y", 32'(a_y), 32'd1);
    fc_held = a_fc;
    step(1'b0, 1'b0);
    chk("a_idle_de", 32'(a_de), 32'd0);
    chk("a_idle_fc_hold", 32'(a_fc), 32'(fc_held));
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("a_restart_fs", 32'(a_fs), 32'd1);
    chk("a_restart_fc", 32'(a_fc), 32'(2'(fc_held + 2'd1)));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    // Randomized run/reset activity.
    for (int i = 0; i < 600; i++)
      step(1'b0 || ($urandom_range(0, 99) == 0), $urandom_range(0, 19) != 0);

    // Mid-line reset clears the frame count on the next edge.
    for (int i = 0; i < 3 * FR; i++) step(1'b0, 1'b1);
    for (int i = 0; i < HT && (ta % HT) != 3; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("a_midline_rst_fc", 32'(a_fc), 32'd0);
    chk("b_midline_rst_fc", 32'(b_fc), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
